// File: rtl/dbg_console_monitor_if.sv
// Bus snoop + character stream interface for dbg_console_monitor.
// master: the CPU/memory bus and the character consumer (bench or debug port).
// slave : the monitor itself.
interface dbg_console_monitor_if #(
  parameter int CHW = 1
);
  logic           bus_valid;
  logic           bus_we;
  logic [31:0]    address;
  logic [31:0]    data_write;
  logic           char_ready;
  logic           char_valid;
  logic [7:0]     char_data;
  logic [CHW-1:0] char_chan;

  modport master (
    output bus_valid, bus_we, address, data_write, char_ready,
    input  char_valid, char_data, char_chan
  );

  modport slave (
    input  bus_valid, bus_we, address, data_write, char_ready,
    output char_valid, char_data, char_chan
  );
endinterface

// File: rtl/dbg_console_monitor.sv
// dbg_console_monitor: snoops the hf-riscv bus, captures console character
// writes from NUM_CH channels, auto-wraps long lines and queues {chan, char}
// in a FIFO drained by a valid/ready consumer. Also keeps sticky halt,
// fault (with first fault address) and a saturating IRQ-vector counter.
// Optional build macro: DBG_MON_CR_STRIP_EN -- when defined, 0x0D writes are
// silently discarded; otherwise 0x0D is an ordinary printable character.

// Per-channel line counter: counts printable characters since the last
// newline and reports when the line is full.
module dbg_con_line_ctr #(
  parameter  int LINE_MAX = 72,
  localparam int LCW      = $clog2(LINE_MAX + 1)
) (
  input  logic clock_in,
  input  logic reset,
  input  logic acc_i,    // capture on this channel accepted into FIFO
  input  logic nl_i,     // captured character is a newline
  output logic wrap_o    // line is full; next printable char forces a newline
);
  logic [LCW-1:0] lc_q, lc_d;

  assign wrap_o = (lc_q == LCW'(LINE_MAX));

  // Next count: newline resets, wrap restarts at 1 (the char after the
  // inserted newline), otherwise increment.
  always_comb begin
    lc_d = lc_q;
    if (acc_i) begin
      if (nl_i)        lc_d = '0;
      else if (wrap_o) lc_d = LCW'(1);
      else             lc_d = lc_q + LCW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock_in) begin
    if (reset) lc_q <= '0;
    else       lc_q <= lc_d;
  end
endmodule

module dbg_console_monitor #(
  parameter  int          NUM_CH    = 2,
  parameter  logic [31:0] CON_BASE  = 32'hf00000d0,
  parameter  int          LINE_MAX  = 72,
  parameter  int          DEPTH     = 16,
  parameter  logic [31:0] HALT_ADDR = 32'he0000000,
  parameter  logic [31:0] MEM_TOP   = 32'h50000000,
  parameter  logic [31:0] IO_BASE   = 32'hf0000000,
  parameter  logic [31:0] IRQ_VEC   = 32'h40000100,
  localparam int          CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock_in,
  input  logic                   reset,
  dbg_console_monitor_if.slave   bus,
  output logic                   overflow,
  output logic                   halt,
  output logic                   fault,
  output logic [31:0]            fault_addr,
  output logic [15:0]            irq_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [7:0]     c;
  } ent_t;

  // ---------------------------------------------------------------- state
  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [15:0]   irq_q, irq_d;

  // ---------------------------------------------------------------- decode
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] wrap;
  logic [CHW-1:0]    cap_ch;
  logic [7:0]        c;
  logic              is_nl;
  logic              cr_drop;
  logic              cap;
  logic              need2;
  logic [CW-1:0]     free;
  logic              room;
  logic              push_ok;
  logic              pop;
  logic [1:0]        npush;
  logic [PW-1:0]     wr_nxt;
  logic              unused_bits;

  assign c           = bus.data_write[31:24];
  assign unused_bits = ^bus.data_write[23:0];
  assign is_nl       = (c == 8'h0A);

`ifdef DBG_MON_CR_STRIP_EN
  assign cr_drop = (c == 8'h0D);
`else
  assign cr_drop = 1'b0;
`endif

  // One counter per channel; accepted captures advance only their channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hit[gi] = bus.bus_valid && bus.bus_we &&
                     (bus.address == CON_BASE + 32'(4 * gi));
    dbg_con_line_ctr #(.LINE_MAX(LINE_MAX)) u_lc (
      .clock_in (clock_in),
      .reset    (reset),
      .acc_i    (push_ok && hit[gi]),
      .nl_i     (is_nl),
      .wrap_o   (wrap[gi])
    );
  end

  // Encode the (at most one) hit channel into its index.
  always_comb begin
    cap_ch = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (hit[i]) cap_ch = CHW'(i);
  end

  // A full line needs two slots (newline + char). Room is judged against
  // the pre-pop count so a same-cycle pop never makes space.
  assign cap     = (|hit) && !halt_q && !cr_drop;
  assign need2   = !is_nl && wrap[cap_ch];
  assign free    = CW'(DEPTH) - count_q;
  assign room    = need2 ? (free >= CW'(2)) : (free >= CW'(1));
  assign push_ok = cap && room;
  assign pop     = (count_q != '0) && bus.char_ready;
  assign npush   = push_ok ? (need2 ? 2'd2 : 2'd1) : 2'd0;
  assign wr_nxt  = wr_ptr_q + PW'(1);

  // ---------------------------------------------------------------- outputs
  assign bus.char_valid = (count_q != '0);
  assign bus.char_data  = bus.char_valid ? mem_q[rd_ptr_q].c  : 8'h00;
  assign bus.char_chan  = bus.char_valid ? mem_q[rd_ptr_q].ch : '0;
  assign overflow       = overflow_q;
  assign halt           = halt_q;
  assign fault          = fault_q;
  assign fault_addr     = fault_addr_q;
  assign irq_count      = irq_q;

  // Pointer / count / sticky-status next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PW'(npush);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(npush) - CW'(pop);
    overflow_d   = overflow_q | (cap && !room);
    halt_d       = halt_q | (bus.bus_valid && (bus.address == HALT_ADDR));
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    irq_d        = irq_q;
    if (bus.bus_valid && (bus.address > MEM_TOP) && (bus.address < IO_BASE)) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = bus.address;
    end
    if (bus.bus_valid && (bus.address == IRQ_VEC) && (irq_q != 16'hFFFF))
      irq_d = irq_q + 16'd1;
  end

  // Control and status registers.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      halt_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      irq_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      halt_q       <= halt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      irq_q        <= irq_d;
    end
  end

  // FIFO storage; a wrap writes the inserted newline first, then the char.
  always_ff @(posedge clock_in) begin
    if (!reset && push_ok) begin
      if (need2) begin
        mem_q[wr_ptr_q] <= '{ch: cap_ch, c: 8'h0A};
        mem_q[wr_nxt]   <= '{ch: cap_ch, c: c};
      end else begin
        mem_q[wr_ptr_q] <= '{ch: cap_ch, c: c};
      end
    end
  end
endmodule

// File: tb/tb_dbg_console_monitor.sv
// Bench for dbg_console_monitor: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all checked against a
// queue-based reference model of the console/status rules.
module tb_dbg_console_monitor;
  localparam int          NUM_CH    = 2;
  localparam logic [31:0] CON_BASE  = 32'hf00000d0;
  localparam int          LINE_MAX  = 72;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] HALT_ADDR = 32'he0000000;
  localparam logic [31:0] MEM_TOP   = 32'h50000000;
  localparam logic [31:0] IO_BASE   = 32'hf0000000;
  localparam logic [31:0] IRQ_VEC   = 32'h40000100;
  localparam int          CHW       = 1;
`ifdef DBG_MON_CR_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        overflow, halt, fault;
  logic [31:0] fault_addr;
  logic [15:0] irq_count;

  dbg_console_monitor_if #(.CHW(CHW)) bus ();

  dbg_console_monitor #(
    .NUM_CH(NUM_CH), .CON_BASE(CON_BASE), .LINE_MAX(LINE_MAX), .DEPTH(DEPTH),
    .HALT_ADDR(HALT_ADDR), .MEM_TOP(MEM_TOP), .IO_BASE(IO_BASE), .IRQ_VEC(IRQ_VEC)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .halt       (halt),
    .fault      (fault),
    .fault_addr (fault_addr),
    .irq_count  (irq_count)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct { int ch; logic [7:0] c; } ent_t;
  ent_t        mq[$];     // characters waiting in the FIFO
  ent_t        plog[$];   // characters handed to the consumer
  int          mlc[NUM_CH];
  bit          movf, mhalt, mfault;
  logic [31:0] mfa;
  int          mirq;

  function automatic ent_t mk(int ch, logic [7:0] c);
    ent_t e;
    e.ch = ch;
    e.c  = c;
    return e;
  endfunction

  // Apply one clock edge of the console rules to the model.
  task automatic model_step();
    bit         pop;
    int         free, need;
    logic [7:0] c;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NUM_CH; i++) mlc[i] = 0;
      movf = 0; mhalt = 0; mfault = 0; mfa = 0; mirq = 0;
      return;
    end
    pop  = (mq.size() != 0) && bus.char_ready;
    free = DEPTH - mq.size();
    if (pop) plog.push_back(mq[0]);
    if (bus.bus_valid && bus.bus_we && !mhalt)
      for (int i = 0; i < NUM_CH; i++)
        if (bus.address == CON_BASE + 4 * i) begin
          c = bus.data_write[31:24];
          if (!(STRIP && c == 8'h0D)) begin
            need = (c != 8'h0A && mlc[i] == LINE_MAX) ? 2 : 1;
            if (free < need) movf = 1;
            else begin
              if (need == 2) begin mq.push_back(mk(i, 8'h0A)); mlc[i] = 0; end
              mq.push_back(mk(i, c));
              mlc[i] = (c == 8'h0A) ? 0 : mlc[i] + 1;
            end
          end
        end
    if (pop) void'(mq.pop_front());
    if (bus.bus_valid && bus.address == HALT_ADDR) mhalt = 1;
    if (bus.bus_valid && bus.address > MEM_TOP && bus.address < IO_BASE) begin
      if (!mfault) mfa = bus.address;
      mfault = 1;
    end
    if (bus.bus_valid && bus.address == IRQ_VEC && mirq < 65535) mirq++;
  endtask

  task automatic chk_model();
    chk("m_valid", bus.char_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_data", bus.char_data, mq[0].c);
      chk("m_chan", bus.char_chan, mq[0].ch);
    end
    chk("m_overflow", overflow, movf);
    chk("m_halt", halt, mhalt);
    chk("m_fault", fault, mfault);
    chk("m_fault_addr", fault_addr, mfa);
    chk("m_irq", irq_count, mirq);
  endtask

  // One clock: model follows the edge, outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clock_in);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic drive(bit v, bit we, logic [31:0] a, logic [7:0] c, bit r);
    bus.bus_valid  = v;
    bus.bus_we     = we;
    bus.address    = a;
    bus.data_write = {c, 24'($urandom)};
    bus.char_ready = r;
  endtask

  task automatic wr(int ch, logic [7:0] c, bit r);
    drive(1, 1, CON_BASE + 32'(4 * ch), c, r);
    cyc();
  endtask

  task automatic idle(int n, bit r);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 32'h0, 8'h00, r);
      cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2, 0);
    reset = 1'b0;
    plog.delete();
  endtask

  task automatic chk_log(string nm, ent_t exp[$]);
    chk({nm, "_len"}, plog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < plog.size(); i++) begin
      chk({nm, "_char"}, plog[i].c, exp[i].c);
      chk({nm, "_chan"}, plog[i].ch, exp[i].ch);
    end
  endtask

  task automatic rand_phase(int n, int rdy_pct, int nl_pct, bit allow_halt);
    for (int k = 0; k < n; k++) begin
      int          sel, cs;
      logic [31:0] a;
      logic [7:0]  c;
      sel = $urandom_range(0, 99);
      if (sel < 30)      a = CON_BASE;
      else if (sel < 55) a = CON_BASE + 32'd4;
      else if (sel < 60) a = CON_BASE + 32'd8;
      else if (sel < 65) a = IRQ_VEC;
      else if (sel < 70) begin
        case ($urandom_range(0, 4))
          0:       a = MEM_TOP;
          1:       a = MEM_TOP + 32'd1;
          2:       a = IO_BASE - 32'd1;
          3:       a = IO_BASE;
          default: a = 32'h50000001 + ($urandom % 32'h9ffffffe);
        endcase
      end
      else if (sel < 71 && allow_halt) a = HALT_ADDR;
      else a = $urandom & 32'h3fffffff;
      cs = $urandom_range(0, 99);
      if (cs < nl_pct)          c = 8'h0A;
      else if (cs < nl_pct + 4) c = 8'h0D;
      else                      c = 8'($urandom_range(32, 126));
      drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70, a, c,
            $urandom_range(0, 99) < rdy_pct);
      cyc();
    end
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    bit v; bit we; logic [31:0] a; logic [7:0] c; bit r;
    bit ev; logic [7:0] ed; bit ef; logic [31:0] efa; bit eh; logic [15:0] eirq;
  } vec_t;
  vec_t tbl[12];

  initial begin
    ent_t exp[$];
    drive(0, 0, 32'h0, 8'h00, 0);

    tbl[0]  = '{1, 1, CON_BASE,     8'h48, 1, 1, 8'h48, 0, 32'h0,        0, 16'd0};
    tbl[1]  = '{1, 1, CON_BASE,     8'h69, 1, 1, 8'h69, 0, 32'h0,        0, 16'd0};
    tbl[2]  = '{1, 1, CON_BASE,     8'h0A, 1, 1, 8'h0A, 0, 32'h0,        0, 16'd0};
    tbl[3]  = '{0, 0, 32'h0,        8'h00, 1, 0, 8'h00, 0, 32'h0,        0, 16'd0};
    tbl[4]  = '{1, 0, 32'h60000000, 8'h00, 1, 0, 8'h00, 1, 32'h60000000, 0, 16'd0};
    tbl[5]  = '{1, 1, 32'h70000000, 8'h00, 1, 0, 8'h00, 1, 32'h60000000, 0, 16'd0};
    tbl[6]  = '{1, 0, IRQ_VEC,      8'h00, 1, 0, 8'h00, 1, 32'h60000000, 0, 16'd1};
    tbl[7]  = '{1, 1, IRQ_VEC,      8'h00, 1, 0, 8'h00, 1, 32'h60000000, 0, 16'd2};
    tbl[8]  = '{1, 0, IRQ_VEC,      8'h00, 1, 0, 8'h00, 1, 32'h60000000, 0, 16'd3};
    tbl[9]  = '{1, 0, HALT_ADDR,    8'h00, 1, 0, 8'h00, 1, 32'h60000000, 1, 16'd3};
    tbl[10] = '{1, 1, CON_BASE,     8'h5A, 1, 0, 8'h00, 1, 32'h60000000, 1, 16'd3};
    tbl[11] = '{0, 0, 32'h0,        8'h00, 1, 0, 8'h00, 1, 32'h60000000, 1, 16'd3};

    do_reset();
    chk("rst_valid", bus.char_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_irq", irq_count, 16'h0);

    // Table: "Hi\n", fault window, IRQ count, halt blocks later capture.
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].v, tbl[k].we, tbl[k].a, tbl[k].c, tbl[k].r);
      cyc();
      chk("t_valid", bus.char_valid, tbl[k].ev);
      if (tbl[k].ev) chk("t_data", bus.char_data, tbl[k].ed);
      chk("t_overflow", overflow, 1'b0);
      chk("t_fault", fault, tbl[k].ef);
      chk("t_fault_addr", fault_addr, tbl[k].efa);
      chk("t_halt", halt, tbl[k].eh);
      chk("t_irq", irq_count, tbl[k].eirq);
    end

    // 73 'A' on ch1: newline auto-inserted before the 73rd.
    do_reset();
    for (int k = 0; k < 73; k++) wr(1, 8'h41, 1);
    idle(6, 1);
    exp.delete();
    for (int k = 0; k < 72; k++) exp.push_back(mk(1, 8'h41));
    exp.push_back(mk(1, 8'h0A));
    exp.push_back(mk(1, 8'h41));
    chk_log("wrap73", exp);
    // The line now holds one char: 71 more fill it, the 72nd wraps again.
    plog.delete();
    for (int k = 0; k < 72; k++) wr(1, 8'h41, 1);
    idle(6, 1);
    exp.delete();
    for (int k = 0; k < 71; k++) exp.push_back(mk(1, 8'h41));
    exp.push_back(mk(1, 8'h0A));
    exp.push_back(mk(1, 8'h41));
    chk_log("wrap_cont", exp);

    // 17 writes into a stalled 16-deep FIFO.
    do_reset();
    for (int k = 0; k < 17; k++) wr(0, 8'(8'h61 + k), 0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_valid", bus.char_valid, 1'b1);
    idle(20, 1);
    exp.delete();
    for (int k = 0; k < 16; k++) exp.push_back(mk(0, 8'(8'h61 + k)));
    chk_log("ovf_drain", exp);
    chk("ovf_sticky", overflow, 1'b1);

    // Interleaved channels, no wrap expected.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      wr(0, 8'h78, 1);
      wr(1, 8'h79, 1);
    end
    idle(4, 1);
    exp.delete();
    for (int k = 0; k < 40; k++) begin
      exp.push_back(mk(0, 8'h78));
      exp.push_back(mk(1, 8'h79));
    end
    chk_log("interleave", exp);

    // Carriage return handling.
    do_reset();
    wr(0, 8'h0D, 1);
    wr(0, 8'h61, 1);
    idle(4, 1);
    exp.delete();
    if (!STRIP) exp.push_back(mk(0, 8'h0D));
    exp.push_back(mk(0, 8'h61));
    chk_log("cr", exp);

    // Randomized traffic against the model.
    do_reset();
    rand_phase(1500, 90, 1, 0);
    rand_phase(1000, 25, 5, 0);
    do_reset();
    rand_phase(800, 60, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dbg_console_monitor.md
Name: dbg_console_monitor

Overview:
- Synthesizable, parametrised bus-snooping debug monitor for the hf-riscv CPU/memory bus.
- Captures character writes to N console channels, wraps long lines automatically and queues {channel, char} in a FIFO drained by a valid/ready consumer.
- Flags end-of-simulation (halt address), out-of-region accesses and IRQ-vector fetches as sticky status for the bench or an on-chip debug port.

Parameters:
- NUM_CH, 2, number of console channels; channel i is at CON_BASE + 4*i.
- CON_BASE, 32'hf00000d0, address of channel 0.
- LINE_MAX, 72, printable characters per line before a newline is auto-inserted.
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- HALT_ADDR, 32'he0000000, access to this address sets halt.
- MEM_TOP, 32'h50000000, fault window lower bound (exclusive).
- IO_BASE, 32'hf0000000, fault window upper bound (exclusive).
- IRQ_VEC, 32'h40000100, IRQ vector address.

Ports:
- clock_in  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bus_valid  in  1  bus access this cycle.
- bus_we  in  1  access is a write.
- address  in  32  bus address.
- data_write  in  32  write data; character in [31:24].
- char_ready  in  1  consumer accepts the FIFO head.
- char_valid  out  1  FIFO not empty.
- char_data  out  8  FIFO head character.
- char_chan  out  max(1,$clog2(NUM_CH))  FIFO head channel.
- overflow  out  1  sticky: a character was dropped.
- halt  out  1  sticky: halt address accessed.
- fault  out  1  sticky: access inside the fault window.
- fault_addr  out  32  address of the first fault.
- irq_count  out  16  saturating count of IRQ_VEC accesses.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO empty, all line counters 0. Reset mid-operation discards FIFO contents.
- Capture condition: bus_valid && bus_we && address == CON_BASE + 4*i for i < NUM_CH && !halt. c = data_write[31:24].
- Per-channel line counter lc[i], width $clog2(LINE_MAX+1):
  - c == 8'h0A: push {i, 0x0A}; lc[i] <= 0.
  - c != 0x0A and lc[i] < LINE_MAX: push {i, c}; lc[i] <= lc[i] + 1.
  - c != 0x0A and lc[i] == LINE_MAX: push {i, 0x0A} then {i, c} in the same cycle (dual push, newline first); lc[i] <= 1.
- Free space is computed as DEPTH − count before this cycle's pop; a same-cycle pop does not make room.
- If free space is less than the entries required (1 or 2): the whole capture is dropped, lc[i] is unchanged and overflow <= 1. Partial pushes never occur.
- Pop when char_valid && char_ready. Outputs are a combinational view of the head register/array.
- Push and pop may occur in the same cycle; count updates by pushes − pops.
- Latency: a character captured at edge N is visible on char_valid/char_data after edge N (when the FIFO was empty).
- halt: set on bus_valid && address == HALT_ADDR, read or write. Captures are ignored from the following cycle. Cleared only by reset.
- fault: set on bus_valid && MEM_TOP < address < IO_BASE. fault_addr latches only the first fault; later faults leave it unchanged.
- irq_count: +1 on each bus_valid && address == IRQ_VEC cycle; saturates at 16'hFFFF.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.

Optional Feature:
- DBG_MON_CR_STRIP_EN defined: captures with c == 8'h0D are discarded. Nothing is pushed, the counter is unchanged and overflow is unaffected.
- Undefined: 0x0D is treated as an ordinary printable character and counts toward LINE_MAX.

Test Plan:
- Write 'H','i',0x0A to ch0 with char_ready=1 -> FIFO outputs {0,'H'},{0,'i'},{0,0x0A}; lc[0] = 0; overflow = 0.
- 73 consecutive 'A' writes to ch1, LINE_MAX=72, consumer always ready -> 72 'A', then 0x0A, then 'A'; lc[1] = 1.
- char_ready=0, DEPTH=16: 17 writes to ch0 -> 16 entries held, overflow = 1. Then drain -> exactly the first 16 characters in order.
- Interleave ch0 'x' and ch1 'y' writes, 40 each -> char_chan tags correct; each channel's lc advances independently, no wrap.
- Accesses to 0x60000000 then 0x70000000 -> fault = 1, fault_addr = 0x60000000. Three IRQ_VEC accesses -> irq_count = 3. Access 0xe0000000, then a ch0 write -> halt = 1 and no push.
- DBG_MON_CR_STRIP_EN defined, write 0x0D,'a' -> only 'a' enqueued. Undefined -> 0x0D then 'a'.
